router_reg_p: RTL and testbench

Parametrised packet-register stage of the router: sits between the input FSM and the per-channel FIFOs. It latches the header, buffers one byte during FIFO-full stalls, forwards bytes to dout, and computes a packet check. It also verifies payload length against the header, flagging errors. It generalises the fixed 8-bit/3-channel/XOR register with configurable width, channel count, check mode and length checking.

---
 rtl/router_pkg.sv | 16 +
 rtl/router_chk_acc.sv | 47 ++++
 rtl/router_reg_p.sv | 183 ++++++++++++++++++
 tb/tb_router_reg_p.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared constants for the router packet path: check modes and header geometry.
package router_pkg;

   localparam int unsigned CHK_XOR    = 0;
   localparam int unsigned CHK_SUM    = 1;

   localparam int unsigned DEF_DW     = 8;
   localparam int unsigned DEF_ADDR_W = 2;
   localparam int unsigned DEF_NUM_CH = 3;

   // Payload-length field width: everything above the address field.
   function automatic int unsigned len_w(input int unsigned dw, input int unsigned addr_w);
      return dw - addr_w;
   endfunction

endpackage

// File: rtl/router_chk_acc.sv
// Running packet-check accumulator (XOR parity or modular sum), shared with the FIFO-side checker.
module router_chk_acc
   import router_pkg::*;
#(
   parameter int unsigned DW       = DEF_DW,
   parameter int unsigned CHK_MODE = CHK_XOR
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          clr,
   input  logic          load,
   input  logic [DW-1:0] load_val,
   input  logic          upd,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] acc
);

   logic [DW-1:0] acc_q;
   logic [DW-1:0] acc_d;

   // Clear beats load beats update.
   always_comb begin
      acc_d = acc_q;
      if (clr) begin
         acc_d = '0;
      end else if (load) begin
         acc_d = load_val;
      end else if (upd) begin
         if (CHK_MODE == CHK_SUM) begin
            acc_d = acc_q + din;
         end else begin
            acc_d = acc_q ^ din;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/router_reg_p.sv
// Router packet-register stage: header latch, one-byte stall buffer, byte forwarding,
// packet check and header-length / address validation.
module router_reg_p
   import router_pkg::*;
#(
   parameter int unsigned DW       = DEF_DW,
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned NUM_CH   = DEF_NUM_CH,
   parameter int unsigned CHK_MODE = CHK_XOR
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          pkt_valid,
   input  logic [DW-1:0] data_in,
   input  logic          fifo_full,
   input  logic          rst_int_reg,
   input  logic          detect_add,
   input  logic          lfd_state,
   input  logic          ld_state,
   input  logic          laf_state,
   input  logic          full_state,
   output logic [DW-1:0] dout,
   output logic          parity_done,
   output logic          low_pkt_valid,
   output logic          err,
   output logic          len_err,
   output logic          addr_err
);

   localparam int unsigned LW = len_w(DW, ADDR_W);

   logic [DW-1:0] hdr_q,  hdr_d;
   logic [DW-1:0] ffb_q,  ffb_d;
   logic [DW-1:0] chk_q,  chk_d;
   logic [DW-1:0] dout_q, dout_d;
   logic [LW-1:0] cnt_q,  cnt_d;
   logic          ovf_q,  ovf_d;
   logic          pd_q,   pd_d;
   logic          low_q,  low_d;
   logic          err_q,  err_d;
   logic          lerr_q, lerr_d;
   logic          aerr_q, aerr_d;
   logic          eval_q, eval_d;

   logic          acc_clr;
   logic          acc_load;
   logic          acc_upd;
   logic          addr_ok;
   logic [DW-1:0] acc;
   logic [LW-1:0] hdr_len;

   assign hdr_len = hdr_q[DW-1:ADDR_W];
   assign addr_ok = (32'(data_in[ADDR_W-1:0]) < NUM_CH);

   router_chk_acc #(
      .DW       (DW),
      .CHK_MODE (CHK_MODE)
   ) u_chk_acc (
      .clock    (clock),
      .reset    (reset),
      .clr      (acc_clr),
      .load     (acc_load),
      .load_val (hdr_q),
      .upd      (acc_upd),
      .din      (data_in),
      .acc      (acc)
   );

   // Strobe decode in priority order: detect_add > lfd > ld > laf; full_state only holds.
   always_comb begin
      hdr_d    = hdr_q;
      ffb_d    = ffb_q;
      chk_d    = chk_q;
      dout_d   = dout_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      pd_d     = pd_q;
      low_d    = low_q;
      err_d    = err_q;
      lerr_d   = lerr_q;
      aerr_d   = aerr_q;
      eval_d   = 1'b0;
      acc_clr  = 1'b0;
      acc_load = 1'b0;
      acc_upd  = 1'b0;

      // Check byte was captured last cycle; the accumulator is stable now.
      if (eval_q) begin
         err_d  = (acc != chk_q);
         lerr_d = (cnt_q != hdr_len) | ovf_q;
      end

      if (detect_add) begin
         if (pkt_valid) begin
            if (addr_ok) begin
               hdr_d = data_in;
            end
            aerr_d  = ~addr_ok;
            acc_clr = 1'b1;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            pd_d    = 1'b0;
            err_d   = 1'b0;
            lerr_d  = 1'b0;
         end
      end else if (lfd_state) begin
         dout_d   = hdr_q;
         acc_load = 1'b1;
      end else if (ld_state) begin
         if (pkt_valid && !full_state) begin
            acc_upd = 1'b1;
            // A byte beyond a saturated count must still register as a length error.
            if (cnt_q == '1) begin
               ovf_d = 1'b1;
            end else begin
               cnt_d = cnt_q + LW'(1);
            end
         end
         if (fifo_full) begin
            ffb_d = data_in;
         end else begin
            dout_d = data_in;
         end
         if (!pkt_valid) begin
            low_d = 1'b1;
            if (!fifo_full) begin
               chk_d  = data_in;
               pd_d   = 1'b1;
               eval_d = 1'b1;
            end
         end
      end else if (laf_state) begin
         dout_d = ffb_q;
         if (low_q && !pd_q) begin
            chk_d  = ffb_q;
            pd_d   = 1'b1;
            eval_d = 1'b1;
         end
      end

      if (rst_int_reg) begin
         low_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         hdr_q  <= '0;
         ffb_q  <= '0;
         chk_q  <= '0;
         dout_q <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
         pd_q   <= 1'b0;
         low_q  <= 1'b0;
         err_q  <= 1'b0;
         lerr_q <= 1'b0;
         aerr_q <= 1'b0;
         eval_q <= 1'b0;
      end else begin
         hdr_q  <= hdr_d;
         ffb_q  <= ffb_d;
         chk_q  <= chk_d;
         dout_q <= dout_d;
         cnt_q  <= cnt_d;
         ovf_q  <= ovf_d;
         pd_q   <= pd_d;
         low_q  <= low_d;
         err_q  <= err_d;
         lerr_q <= lerr_d;
         aerr_q <= aerr_d;
         eval_q <= eval_d;
      end
   end

   assign dout          = dout_q;
   assign parity_done   = pd_q;
   assign low_pkt_valid = low_q;
   assign err           = err_q;
   assign len_err       = lerr_q;
   assign addr_err      = aerr_q;

endmodule

// File: tb/tb_router_reg_p.sv
// Directed bench for router_reg_p: XOR and sum instances driven in lockstep.
module tb_router_reg_p;

   localparam logic [4:0] S_N = 5'b00000;
   localparam logic [4:0] S_D = 5'b10000;
   localparam logic [4:0] S_F = 5'b01000;
   localparam logic [4:0] S_L = 5'b00100;
   localparam logic [4:0] S_A = 5'b00010;
   localparam logic [4:0] S_U = 5'b00001;

   typedef struct packed {
      logic [4:0] st;
      logic       pv;
      logic       ff;
      logic       ri;
      logic [7:0] din;
      logic [7:0] e_dout;
      logic       e_pd;
      logic       e_low;
      logic       e_err;
      logic       e_lerr;
      logic       e_aerr;
   } vec_t;

   logic       clock = 1'b0;
   logic       reset;
   logic       pkt_valid, fifo_full, rst_int_reg;
   logic       detect_add, lfd_state, ld_state, laf_state, full_state;
   logic [7:0] data_in;

   logic [7:0] dout_x, dout_s;
   logic       pd_x, pd_s, low_x, low_s, err_x, err_s, lerr_x, lerr_s, aerr_x, aerr_s;

   int tests_run = 0;
   int tests_failed = 0;

   vec_t tbl [24];

   always #5 clock = ~clock;

   router_reg_p #(.DW(8), .ADDR_W(2), .NUM_CH(3), .CHK_MODE(0)) dut_x (
      .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
      .fifo_full(fifo_full), .rst_int_reg(rst_int_reg), .detect_add(detect_add),
      .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
      .full_state(full_state), .dout(dout_x), .parity_done(pd_x),
      .low_pkt_valid(low_x), .err(err_x), .len_err(lerr_x), .addr_err(aerr_x)
   );

   router_reg_p #(.DW(8), .ADDR_W(2), .NUM_CH(3), .CHK_MODE(1)) dut_s (
      .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
      .fifo_full(fifo_full), .rst_int_reg(rst_int_reg), .detect_add(detect_add),
      .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
      .full_state(full_state), .dout(dout_s), .parity_done(pd_s),
      .low_pkt_valid(low_s), .err(err_s), .len_err(lerr_s), .addr_err(aerr_s)
   );

   function automatic vec_t v(input logic [4:0] st, input logic pv, input logic ff,
                              input logic ri, input logic [7:0] din, input logic [7:0] e_dout,
                              input logic e_pd, input logic e_low, input logic e_err,
                              input logic e_lerr, input logic e_aerr);
      vec_t r;
      r = '{st, pv, ff, ri, din, e_dout, e_pd, e_low, e_err, e_lerr, e_aerr};
      return r;
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
   task automatic drive(input logic [4:0] st, input logic pv, input logic ff,
                        input logic ri, input logic [7:0] d);
      @(negedge clock);
      reset = 1'b0;
      {detect_add, lfd_state, ld_state, laf_state, full_state} = st;
      pkt_valid   = pv;
      fifo_full   = ff;
      rst_int_reg = ri;
      data_in     = d;
      @(posedge clock);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_dout"}, dout_x, 8'h00);
      check({tag, "_pd"},   8'(pd_x), 8'h00);
      check({tag, "_low"},  8'(low_x), 8'h00);
      check({tag, "_err"},  8'(err_x), 8'h00);
      check({tag, "_lerr"}, 8'(lerr_x), 8'h00);
      check({tag, "_aerr"}, 8'(aerr_x), 8'h00);
   endtask

   initial begin
      reset = 1'b1;
      {detect_add, lfd_state, ld_state, laf_state, full_state} = S_N;
      pkt_valid = 1'b0; fifo_full = 1'b0; rst_int_reg = 1'b0; data_in = 8'h00;
      repeat (2) @(posedge clock);
      #1;
      check_all_zero("reset");

      // good XOR packet, bad check byte, short packet, illegal address
      tbl[0]  = v(S_D, 1'b1, 1'b0, 1'b0, 8'h0D, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[1]  = v(S_F, 1'b1, 1'b0, 1'b0, 8'h00, 8'h0D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[2]  = v(S_L, 1'b1, 1'b0, 1'b0, 8'h41, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[3]  = v(S_L, 1'b1, 1'b0, 1'b0, 8'h4C, 8'h4C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[4]  = v(S_L, 1'b1, 1'b0, 1'b0, 8'h2C, 8'h2C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[5]  = v(S_L, 1'b0, 1'b0, 1'b0, 8'h2C, 8'h2C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tbl[6]  = v(S_N, 1'b0, 1'b0, 1'b1, 8'h00, 8'h2C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[7]  = v(S_D, 1'b1, 1'b0, 1'b0, 8'h0D, 8'h2C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[8]  = v(S_F, 1'b1, 1'b0, 1'b0, 8'h00, 8'h0D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[9]  = v(S_L, 1'b1, 1'b0, 1'b0, 8'h41, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[10] = v(S_L, 1'b1, 1'b0, 1'b0, 8'h4C, 8'h4C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[11] = v(S_L, 1'b1, 1'b0, 1'b0, 8'h2C, 8'h2C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[12] = v(S_L, 1'b0, 1'b0, 1'b0, 8'h2D, 8'h2D, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tbl[13] = v(S_N, 1'b0, 1'b0, 1'b0, 8'h00, 8'h2D, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      tbl[14] = v(S_N, 1'b0, 1'b0, 1'b1, 8'h00, 8'h2D, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      tbl[15] = v(S_D, 1'b1, 1'b0, 1'b0, 8'h11, 8'h2D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[16] = v(S_F, 1'b1, 1'b0, 1'b0, 8'h00, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[17] = v(S_L, 1'b1, 1'b0, 1'b0, 8'h41, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[18] = v(S_L, 1'b1, 1'b0, 1'b0, 8'h4C, 8'h4C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[19] = v(S_L, 1'b1, 1'b0, 1'b0, 8'h2C, 8'h2C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[20] = v(S_L, 1'b0, 1'b0, 1'b0, 8'h30, 8'h30, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tbl[21] = v(S_N, 1'b0, 1'b0, 1'b1, 8'h00, 8'h30, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      tbl[22] = v(S_D, 1'b1, 1'b0, 1'b0, 8'h07, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tbl[23] = v(S_F, 1'b1, 1'b0, 1'b0, 8'h00, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      for (int i = 0; i < 24; i++) begin
         drive(tbl[i].st, tbl[i].pv, tbl[i].ff, tbl[i].ri, tbl[i].din);
         check($sformatf("v%0d_dout", i), dout_x, tbl[i].e_dout);
         check($sformatf("v%0d_pd", i),   8'(pd_x),   8'(tbl[i].e_pd));
         check($sformatf("v%0d_low", i),  8'(low_x),  8'(tbl[i].e_low));
         check($sformatf("v%0d_err", i),  8'(err_x),  8'(tbl[i].e_err));
         check($sformatf("v%0d_lerr", i), 8'(lerr_x), 8'(tbl[i].e_lerr));
         check($sformatf("v%0d_aerr", i), 8'(aerr_x), 8'(tbl[i].e_aerr));
      end

      // Modular-sum check: 0x0D+0x41+0x4C+0x2C = 0xC6
      drive(S_D, 1'b1, 1'b0, 1'b0, 8'h0D);
      drive(S_F, 1'b1, 1'b0, 1'b0, 8'h00);
      drive(S_L, 1'b1, 1'b0, 1'b0, 8'h41);
      drive(S_L, 1'b1, 1'b0, 1'b0, 8'h4C);
      drive(S_L, 1'b1, 1'b0, 1'b0, 8'h2C);
      drive(S_L, 1'b0, 1'b0, 1'b0, 8'hC6);
      check("sum_pd", 8'(pd_s), 8'h01);
      drive(S_N, 1'b0, 1'b0, 1'b1, 8'h00);
      check("sum_ok_err", 8'(err_s), 8'h00);
      check("sum_ok_lerr", 8'(lerr_s), 8'h00);
      check("sum_xor_err", 8'(err_x), 8'h01);
      drive(S_D, 1'b1, 1'b0, 1'b0, 8'h0D);
      check("sum_clr_err", 8'(err_x), 8'h00);
      drive(S_F, 1'b1, 1'b0, 1'b0, 8'h00);
      drive(S_L, 1'b1, 1'b0, 1'b0, 8'h41);
      drive(S_L, 1'b1, 1'b0, 1'b0, 8'h4C);
      drive(S_L, 1'b1, 1'b0, 1'b0, 8'h2C);
      drive(S_L, 1'b0, 1'b0, 1'b0, 8'hC7);
      drive(S_N, 1'b0, 1'b0, 1'b1, 8'h00);
      check("sum_bad_err", 8'(err_s), 8'h01);

      // Stall: 0x52 parked in ffb, replayed on laf; check byte also arrives during a stall
      drive(S_D, 1'b1, 1'b0, 1'b0, 8'h0D);
      drive(S_F, 1'b1, 1'b0, 1'b0, 8'h00);
      drive(S_L, 1'b1, 1'b0, 1'b0, 8'h41);
      drive(S_L, 1'b1, 1'b1, 1'b0, 8'h52);
      check("stall_hold", dout_x, 8'h41);
      drive(S_U, 1'b1, 1'b1, 1'b0, 8'h00);
      check("stall_full", dout_x, 8'h41);
      drive(S_A, 1'b1, 1'b0, 1'b0, 8'h00);
      check("stall_laf", dout_x, 8'h52);
      drive(S_L, 1'b1, 1'b0, 1'b0, 8'h2C);
      check("stall_next", dout_x, 8'h2C);
      drive(S_L, 1'b0, 1'b1, 1'b0, 8'h32);
      check("stall_low", 8'(low_x), 8'h01);
      check("stall_nopd", 8'(pd_x), 8'h00);
      drive(S_U, 1'b0, 1'b1, 1'b0, 8'h00);
      drive(S_A, 1'b0, 1'b0, 1'b0, 8'h00);
      check("laf_chk_dout", dout_x, 8'h32);
      check("laf_chk_pd", 8'(pd_x), 8'h01);
      drive(S_N, 1'b0, 1'b0, 1'b0, 8'h00);
      check("laf_chk_err", 8'(err_x), 8'h00);
      check("laf_chk_lerr", 8'(lerr_x), 8'h00);
      // rst_int_reg wins over a concurrent ld & !pkt_valid
      drive(S_L, 1'b0, 1'b1, 1'b1, 8'h00);
      check("ri_wins", 8'(low_x), 8'h00);

      // Length 63: exactly 63 bytes is fine, 64 bytes overflows the saturated counter
      for (int n = 63; n <= 64; n++) begin
         drive(S_D, 1'b1, 1'b0, 1'b0, 8'hFD);
         drive(S_F, 1'b1, 1'b0, 1'b0, 8'h00);
         for (int k = 0; k < n; k++) drive(S_L, 1'b1, 1'b0, 1'b0, 8'h00);
         drive(S_L, 1'b0, 1'b0, 1'b0, 8'hFD);
         drive(S_N, 1'b0, 1'b0, 1'b1, 8'h00);
         check($sformatf("sat%0d_err", n), 8'(err_x), 8'h00);
         check($sformatf("sat%0d_lerr", n), 8'(lerr_x), (n == 64) ? 8'h01 : 8'h00);
      end

      // Reset mid-payload clears every output
      drive(S_D, 1'b1, 1'b0, 1'b0, 8'h0D);
      drive(S_F, 1'b1, 1'b0, 1'b0, 8'h00);
      drive(S_L, 1'b1, 1'b0, 1'b0, 8'h41);
      drive(S_L, 1'b0, 1'b0, 1'b0, 8'h99);
      drive(S_N, 1'b0, 1'b0, 1'b0, 8'h00);
      check("pre_rst_err", 8'(err_x), 8'h01);
      check("pre_rst_lerr", 8'(lerr_x), 8'h01);
      drive(S_L, 1'b1, 1'b0, 1'b0, 8'h55);
      check("pre_rst_dout", dout_x, 8'h55);
      check("pre_rst_low", 8'(low_x), 8'h01);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check_all_zero("midrst");
      reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
